// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: serial input, configuration and status.
// The match_count signal exists only when SEQ_DET_MATCH_COUNT_EN is defined.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               en;
  logic               i;
  logic               i_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               out;
  logic               armed;
`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [CNT_W-1:0]   match_count;
`endif

  // Reject parameter values the detector cannot represent.
  if (MAX_LEN < 2 || CNT_W < 1) begin : g_param_check
    $error("seq_detector_param_if: MAX_LEN must be >= 2 and CNT_W >= 1");
  end

  // Stimulus / configuration side.
  modport master (
    output en, i, i_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
`ifdef SEQ_DET_MATCH_COUNT_EN
    input  match_count,
`endif
    input  out, armed
  );

  // Detector side.
  modport slave (
    input  en, i, i_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
`ifdef SEQ_DET_MATCH_COUNT_EN
    output match_count,
`endif
    output out, armed
  );
endinterface

// File: rtl/seq_detector_param.sv
// Programmable serial sequence detector.
// Matches a runtime-loaded pattern of 1..MAX_LEN bits (first bit received is
// pattern[len-1]) in overlapping or non-overlapping mode, emitting a one-cycle
// registered pulse on bus.out one cycle after the completing bit.
// Optional feature: define SEQ_DET_MATCH_COUNT_EN to add a saturating
// match counter on bus.match_count.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  seq_detector_param_if.slave  bus
);
  localparam int               LEN_W    = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    DETECT = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [MAX_LEN-1:0] hist_reg, hist_next;
  logic [MAX_LEN-1:0] pattern_reg, pattern_next;
  logic [LEN_W-1:0]   fill_reg, fill_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic               overlap_reg, overlap_next;
  logic               out_reg, out_next;

  logic               accepted;
  logic               evaluate;
  logic               is_match;
  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   load_len;

  if (MAX_LEN < 2 || CNT_W < 1) begin : g_param_check
    $error("seq_detector_param: MAX_LEN must be >= 2 and CNT_W >= 1");
  end

  // Mask of the low len_reg bits: only these take part in the compare.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_len_mask
    assign len_mask[gi] = (LEN_W'(gi) < len_reg);
  end

  // A bit is consumed only when enabled, valid, not pre-empted by a reload,
  // and the detector has been configured at least once.
  assign accepted = bus.en & bus.i_valid & ~bus.cfg_load & (state_reg != IDLE);
  assign shifted  = {hist_reg[MAX_LEN-2:0], bus.i};
  assign is_match = ((shifted ^ pattern_reg) & len_mask) == '0;
  assign fill_inc = fill_reg + LEN_W'(1);
  // While filling, the compare is only meaningful once len bits are present.
  assign evaluate = (state_reg == DETECT) |
                    ((state_reg == FILL) & (fill_inc == len_reg));
  // Out-of-range lengths (0 or above MAX_LEN) fall back to the full width.
  assign load_len = (bus.cfg_len == '0 || bus.cfg_len > FULL_LEN) ? FULL_LEN : bus.cfg_len;

  // State register: FSM state, history, fill count, configuration and out pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      hist_reg    <= '0;
      fill_reg    <= '0;
      pattern_reg <= '0;
      len_reg     <= FULL_LEN;
      overlap_reg <= 1'b0;
      out_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hist_reg    <= hist_next;
      fill_reg    <= fill_next;
      pattern_reg <= pattern_next;
      len_reg     <= len_next;
      overlap_reg <= overlap_next;
      out_reg     <= out_next;
    end
  end

  // Next-state logic: reload has priority over any incoming bit.
  always_comb begin
    state_next   = state_reg;
    hist_next    = hist_reg;
    fill_next    = fill_reg;
    pattern_next = pattern_reg;
    len_next     = len_reg;
    overlap_next = overlap_reg;
    if (bus.cfg_load) begin
      state_next   = FILL;
      hist_next    = '0;
      fill_next    = '0;
      pattern_next = bus.cfg_pattern;
      len_next     = load_len;
      overlap_next = bus.cfg_overlap;
    end else if (accepted) begin
      hist_next = shifted;
      case (state_reg)
        FILL: begin
          if (fill_inc == len_reg) begin
            fill_next = '0;
            if (is_match && !overlap_reg) begin
              // Non-overlapping: the matched bits may not seed the next match.
              state_next = FILL;
              hist_next  = '0;
            end else begin
              state_next = DETECT;
            end
          end else begin
            fill_next = fill_inc;
          end
        end
        DETECT: begin
          if (is_match && !overlap_reg) begin
            state_next = FILL;
            fill_next  = '0;
            hist_next  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: pulse request for the next cycle and the armed status.
  always_comb begin
    out_next  = accepted & evaluate & is_match;
    bus.armed = (state_reg == DETECT);
  end

  assign bus.out = out_reg;

`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [CNT_W-1:0] count_reg;

  // Saturating count of out pulses since reset or the last reload.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (bus.cfg_load) begin
      count_reg <= '0;
    end else if (out_next && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign bus.match_count = count_reg;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param. Expected out/armed values are
// pushed to a scoreboard queue as each cycle of stimulus is driven and popped
// once the DUT has registered that cycle.
`timescale 1ns/1ps
module tb_seq_detector_param;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic clock = 1'b0;
  logic reset = 1'b0;

  seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic  out;
    logic  armed;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Drive one cycle of stimulus, record its expected result, wait for the edge.
  task automatic step(input logic s_en, input logic s_valid, input logic s_bit,
                      input logic s_load, input logic e_out, input logic e_armed,
                      input string tag);
    exp_t e;
    bus.en       = s_en;
    bus.i_valid  = s_valid;
    bus.i        = s_bit;
    bus.cfg_load = s_load;
    e.out   = e_out;
    e.armed = e_armed;
    e.tag   = tag;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic set_cfg(input logic [MAX_LEN-1:0] pat, input int len, input logic ovl);
    bus.cfg_pattern = pat;
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_overlap = ovl;
  endtask

  // Row encoding: {en, i_valid, i, cfg_load, expected out, expected armed}
  task automatic test_reset();
    exp_t e;
    logic [5:0] rows[$];
    repeat (2) @(posedge clock);
    #1;
    e.out = 1'b0; e.armed = 1'b0; e.tag = "reset_hold";
    sb.push_back(e);
    e = sb.pop_front();
    vectors++;
    if (bus.out !== e.out || bus.armed !== e.armed) begin
      miscompares++;
      $display("FAIL %s: out=%b armed=%b, expected out=%b armed=%b", e.tag, bus.out, bus.armed, e.out, e.armed);
    end else $display("ok   %s out=%b armed=%b", e.tag, bus.out, bus.armed);
`ifdef SEQ_DET_MATCH_COUNT_EN
    vectors++;
    if (bus.match_count !== '0) begin
      miscompares++;
      $display("FAIL reset_count: match_count=%0d, expected 0", bus.match_count);
    end
`endif
    reset = 1'b1;
    // Unconfigured detector ignores every bit.
    rows = '{6'b11_1_0_00, 6'b11_1_0_00, 6'b11_0_0_00, 6'b11_1_0_00};
    foreach (rows[k]) begin
      step(rows[k][5], rows[k][4], rows[k][3], rows[k][2], rows[k][1], rows[k][0], "idle_ignore");
      e = sb.pop_front();
      vectors++;
      if (bus.out !== e.out || bus.armed !== e.armed) begin
        miscompares++;
        $display("FAIL %s[%0d]: out=%b armed=%b, expected out=%b armed=%b", e.tag, k, bus.out, bus.armed, e.out, e.armed);
      end else $display("ok   %s[%0d] out=%b armed=%b", e.tag, k, bus.out, bus.armed);
    end
  endtask

  task automatic test_overlap();
    exp_t e;
    logic [5:0] rows[$];
    set_cfg(8'b1011, 4, 1'b1);
    rows = '{6'b11_0_1_00,
             6'b11_1_0_00, 6'b11_0_0_00, 6'b11_1_0_00, 6'b11_1_0_11,
             6'b11_0_0_01, 6'b11_1_0_01, 6'b11_1_0_11,
             6'b10_0_0_01};
    foreach (rows[k]) begin
      step(rows[k][5], rows[k][4], rows[k][3], rows[k][2], rows[k][1], rows[k][0], "overlap");
      e = sb.pop_front();
      vectors++;
      if (bus.out !== e.out || bus.armed !== e.armed) begin
        miscompares++;
        $display("FAIL %s[%0d]: out=%b armed=%b, expected out=%b armed=%b", e.tag, k, bus.out, bus.armed, e.out, e.armed);
      end else $display("ok   %s[%0d] out=%b armed=%b", e.tag, k, bus.out, bus.armed);
    end
  endtask

  task automatic test_nonoverlap();
    exp_t e;
    logic [5:0] rows[$];
    set_cfg(8'b1011, 4, 1'b0);
    // Same stream as the overlap case: one pulse only. Then a second load
    // where the first window misses, arming the detector, and the next bit
    // matches and disarms it.
    rows = '{6'b11_0_1_00,
             6'b11_1_0_00, 6'b11_0_0_00, 6'b11_1_0_00, 6'b11_1_0_10,
             6'b11_0_0_00, 6'b11_1_0_00, 6'b11_1_0_00,
             6'b11_0_1_00,
             6'b11_0_0_00, 6'b11_1_0_00, 6'b11_0_0_00, 6'b11_1_0_01,
             6'b11_1_0_10, 6'b11_0_0_00};
    foreach (rows[k]) begin
      step(rows[k][5], rows[k][4], rows[k][3], rows[k][2], rows[k][1], rows[k][0], "nonoverlap");
      e = sb.pop_front();
      vectors++;
      if (bus.out !== e.out || bus.armed !== e.armed) begin
        miscompares++;
        $display("FAIL %s[%0d]: out=%b armed=%b, expected out=%b armed=%b", e.tag, k, bus.out, bus.armed, e.out, e.armed);
      end else $display("ok   %s[%0d] out=%b armed=%b", e.tag, k, bus.out, bus.armed);
    end
  endtask

  task automatic test_len1();
    exp_t e;
    logic [5:0] rows[$];
    set_cfg(8'b1, 1, 1'b1);
    rows = '{6'b11_0_1_00,
             6'b11_1_0_11, 6'b11_1_0_11, 6'b11_1_0_11,
             6'b11_0_0_01, 6'b11_1_0_11};
    foreach (rows[k]) begin
      step(rows[k][5], rows[k][4], rows[k][3], rows[k][2], rows[k][1], rows[k][0], "len1");
      e = sb.pop_front();
      vectors++;
      if (bus.out !== e.out || bus.armed !== e.armed) begin
        miscompares++;
        $display("FAIL %s[%0d]: out=%b armed=%b, expected out=%b armed=%b", e.tag, k, bus.out, bus.armed, e.out, e.armed);
      end else $display("ok   %s[%0d] out=%b armed=%b", e.tag, k, bus.out, bus.armed);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [5:0] rows[$];
    set_cfg(8'b11, 2, 1'b1);
    rows = '{6'b11_0_1_00,
             6'b11_1_0_00, 6'b11_1_0_11, 6'b11_1_0_11, 6'b11_1_0_11,
             6'b11_0_0_01, 6'b11_1_0_01, 6'b11_1_0_11};
    foreach (rows[k]) begin
      step(rows[k][5], rows[k][4], rows[k][3], rows[k][2], rows[k][1], rows[k][0], "back_to_back");
      e = sb.pop_front();
      vectors++;
      if (bus.out !== e.out || bus.armed !== e.armed) begin
        miscompares++;
        $display("FAIL %s[%0d]: out=%b armed=%b, expected out=%b armed=%b", e.tag, k, bus.out, bus.armed, e.out, e.armed);
      end else $display("ok   %s[%0d] out=%b armed=%b", e.tag, k, bus.out, bus.armed);
    end
  endtask

  // Length 0 and length 12 both clamp to the full 8-bit pattern.
  task automatic test_len_clamp();
    exp_t e;
    logic [MAX_LEN-1:0] pat;
    pat = 8'hA5;
    for (int p = 0; p < 2; p++) begin
      set_cfg(pat, (p == 0) ? 0 : 12, (p == 0) ? 1'b0 : 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "clamp_load");
      e = sb.pop_front();
      vectors++;
      if (bus.out !== e.out || bus.armed !== e.armed) begin
        miscompares++;
        $display("FAIL %s[%0d]: out=%b armed=%b, expected out=%b armed=%b", e.tag, p, bus.out, bus.armed, e.out, e.armed);
      end else $display("ok   %s[%0d] out=%b armed=%b", e.tag, p, bus.out, bus.armed);
      for (int b = MAX_LEN - 1; b >= 0; b--) begin
        step(1'b1, 1'b1, pat[b], 1'b0, (b == 0), (b == 0) && (p == 1), "clamp_bit");
        e = sb.pop_front();
        vectors++;
        if (bus.out !== e.out || bus.armed !== e.armed) begin
          miscompares++;
          $display("FAIL %s[%0d.%0d]: out=%b armed=%b, expected out=%b armed=%b", e.tag, p, b, bus.out, bus.armed, e.out, e.armed);
        end else $display("ok   %s[%0d.%0d] out=%b armed=%b", e.tag, p, b, bus.out, bus.armed);
      end
    end
  endtask

  task automatic test_gaps();
    exp_t e;
    logic [5:0] rows[$];
    set_cfg(8'b1011, 4, 1'b1);
    // Ignored bits (i_valid=0 or en=0) carry values that would break or
    // complete the pattern if they were wrongly consumed.
    rows = '{6'b11_0_1_00,
             6'b11_1_0_00, 6'b10_1_0_00, 6'b11_0_0_00, 6'b01_1_0_00,
             6'b11_1_0_00, 6'b01_0_0_00, 6'b10_0_0_00, 6'b11_1_0_11,
             6'b01_1_0_01, 6'b11_0_0_01, 6'b11_1_0_01, 6'b01_1_0_01,
             6'b11_1_0_11};
    foreach (rows[k]) begin
      step(rows[k][5], rows[k][4], rows[k][3], rows[k][2], rows[k][1], rows[k][0], "gaps");
      e = sb.pop_front();
      vectors++;
      if (bus.out !== e.out || bus.armed !== e.armed) begin
        miscompares++;
        $display("FAIL %s[%0d]: out=%b armed=%b, expected out=%b armed=%b", e.tag, k, bus.out, bus.armed, e.out, e.armed);
      end else $display("ok   %s[%0d] out=%b armed=%b", e.tag, k, bus.out, bus.armed);
    end
  endtask

  task automatic test_cfg_collision();
    exp_t e;
    logic [5:0] rows[$];
    set_cfg(8'b1011, 4, 1'b1);
    // Reload on the completing bit discards it; reload with en=0 still works.
    rows = '{6'b11_0_1_00,
             6'b11_1_0_00, 6'b11_0_0_00, 6'b11_1_0_00,
             6'b11_1_1_00,
             6'b11_1_0_00, 6'b11_0_0_00, 6'b11_1_0_00, 6'b11_1_0_11,
             6'b00_0_1_00,
             6'b11_1_0_00, 6'b11_0_0_00, 6'b11_1_0_00, 6'b11_1_0_11};
    foreach (rows[k]) begin
      step(rows[k][5], rows[k][4], rows[k][3], rows[k][2], rows[k][1], rows[k][0], "cfg_collision");
      e = sb.pop_front();
      vectors++;
      if (bus.out !== e.out || bus.armed !== e.armed) begin
        miscompares++;
        $display("FAIL %s[%0d]: out=%b armed=%b, expected out=%b armed=%b", e.tag, k, bus.out, bus.armed, e.out, e.armed);
      end else $display("ok   %s[%0d] out=%b armed=%b", e.tag, k, bus.out, bus.armed);
    end
  endtask

  // Entered with out=1 and armed=1 from the previous scenario.
  task automatic test_async_reset();
    exp_t e;
    logic [5:0] rows[$];
    bus.en = 1'b0; bus.i_valid = 1'b0; bus.i = 1'b0; bus.cfg_load = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    e.out = 1'b0; e.armed = 1'b0; e.tag = "async_reset";
    sb.push_back(e);
    e = sb.pop_front();
    vectors++;
    if (bus.out !== e.out || bus.armed !== e.armed) begin
      miscompares++;
      $display("FAIL %s: out=%b armed=%b, expected out=%b armed=%b", e.tag, bus.out, bus.armed, e.out, e.armed);
    end else $display("ok   %s out=%b armed=%b", e.tag, bus.out, bus.armed);
    @(negedge clock);
    reset = 1'b1;
    set_cfg(8'b1011, 4, 1'b1);
    rows = '{6'b11_1_0_00, 6'b11_0_0_00, 6'b11_1_0_00, 6'b11_1_0_00,
             6'b11_0_1_00,
             6'b11_1_0_00, 6'b11_0_0_00, 6'b11_1_0_00, 6'b11_1_0_11};
    foreach (rows[k]) begin
      step(rows[k][5], rows[k][4], rows[k][3], rows[k][2], rows[k][1], rows[k][0], "post_reset");
      e = sb.pop_front();
      vectors++;
      if (bus.out !== e.out || bus.armed !== e.armed) begin
        miscompares++;
        $display("FAIL %s[%0d]: out=%b armed=%b, expected out=%b armed=%b", e.tag, k, bus.out, bus.armed, e.out, e.armed);
      end else $display("ok   %s[%0d] out=%b armed=%b", e.tag, k, bus.out, bus.armed);
    end
  endtask

`ifdef SEQ_DET_MATCH_COUNT_EN
  task automatic test_match_count();
    exp_t e;
    logic [5:0] rows[$];
    int         cnt_exp[$];
    set_cfg(8'b1, 1, 1'b1);
    rows    = '{6'b11_0_1_00, 6'b11_1_0_11, 6'b11_1_0_11, 6'b11_1_0_11,
                6'b11_1_0_11, 6'b11_1_0_11, 6'b11_0_1_00};
    cnt_exp = '{0, 1, 2, 3, 3, 3, 0};
    foreach (rows[k]) begin
      step(rows[k][5], rows[k][4], rows[k][3], rows[k][2], rows[k][1], rows[k][0], "match_count");
      e = sb.pop_front();
      vectors++;
      if (bus.out !== e.out || bus.armed !== e.armed || bus.match_count !== CNT_W'(cnt_exp[k])) begin
        miscompares++;
        $display("FAIL %s[%0d]: out=%b armed=%b count=%0d, expected out=%b armed=%b count=%0d",
                 e.tag, k, bus.out, bus.armed, bus.match_count, e.out, e.armed, cnt_exp[k]);
      end else $display("ok   %s[%0d] out=%b count=%0d", e.tag, k, bus.out, bus.match_count);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en          = 1'b0;
    bus.i           = 1'b0;
    bus.i_valid     = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_len1();
    test_back_to_back();
    test_len_clamp();
    test_gaps();
    test_cfg_collision();
    test_async_reset();
`ifdef SEQ_DET_MATCH_COUNT_EN
    test_match_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
